// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for a pipelined datapath's memory stage. Accepts one
//   load/store at a time, holds it for LATENCY cycles and answers with a
//   single-cycle data_ok strobe. The storage is a word array split into four
//   byte-lane block RAMs with registered reads.
//
// Ports
//   clk       in   1  clock, all state changes on its rising edge
//   rst       in   1  asynchronous active-low reset
//   req       in   1  request valid
//   memwrite  in   1  1 = store, 0 = load
//   sig_write in   4  byte-lane write enables (lane-aligned)
//   addr      in  32  byte address
//   wdata     in  32  lane-aligned store data
//   rdata     out 32  read word (nonzero only for an error-free load response)
//   data_ok   out  1  one-cycle response strobe
//   busy      out  1  registered, high while a request is outstanding
//   err       out  1  range or enable error, meaningful only with data_ok
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        memwrite,
  input  logic [3:0]  sig_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        data_ok,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 3;
  // Cycles spent in WAIT beyond the first one; unused when LATENCY = 1.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q;

  logic              we_q;
  logic [3:0]        sw_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic              range_err;
  logic              en_err;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] held_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       mem_rdata;

  // Byte offset never takes part in indexing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[1:0];

  assign accept    = (state_q == S_IDLE) && req;
  assign held_idx  = addr_q[ADDR_W+1:2];
  assign range_err = |addr_q[31:ADDR_W+2];
  assign en_err    = we_q && (sw_q == 4'b0000);
  assign resp_err  = range_err || en_err;
  assign mem_we    = (state_q == S_RESP) && we_q && !resp_err;

  // While idle the read port follows the live address so that the word is
  // already in the read register when LATENCY = 1 puts us straight into RESP.
  // Afterwards it keeps re-reading the held address.
  assign rd_idx = (state_q == S_IDLE) ? addr[ADDR_W+1:2] : held_idx;

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    data_ok = 1'b0;
    err     = 1'b0;
    rdata   = '0;
    if (state_q == S_RESP) begin
      data_ok = 1'b1;
      err     = resp_err;
      if (!we_q && !resp_err) begin
        rdata = mem_rdata;
      end
    end
  end

  assign busy = busy_q;

  // ---------------------------------------------------------------- holding regs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      sw_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= memwrite;
      sw_q    <= sig_write;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // ---------------------------------------------------------------- storage
  // One single-port byte RAM per lane; a cycle either writes or reads.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (mem_we) begin
        if (sw_q[gi]) begin
          mem[held_idx] <= wdata_q[8*gi +: 8];
        end
      end else begin
        rd_q <= mem[rd_idx];
      end
    end

    assign mem_rdata[8*gi +: 8] = rd_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit done [2];

  task automatic chk(input int lat, input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL L%0d %s: got %h, expected %h", lat, name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 2 : 1;

    logic        rst_s   = 1'b0;
    logic        req_s   = 1'b0;
    logic        we_s    = 1'b0;
    logic [3:0]  sw_s    = '0;
    logic [31:0] addr_s  = '0;
    logic [31:0] wdata_s = '0;
    logic [31:0] rdata_s;
    logic        ok_s, busy_s, err_s;

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst_s),
      .req       (req_s),
      .memwrite  (we_s),
      .sig_write (sw_s),
      .addr      (addr_s),
      .wdata     (wdata_s),
      .rdata     (rdata_s),
      .data_ok   (ok_s),
      .busy      (busy_s),
      .err       (err_s)
    );

    // ------------------------------------------------ transaction-level model
    // One outstanding access; it is answered LAT cycles after acceptance and
    // the responder is free again one cycle after the answer.
    logic [31:0] mm [int];
    int          edge_n    = 0;
    int          resp_edge = 0;
    int          free_edge = 0;
    bit          pend      = 0;
    bit          p_we      = 0;
    bit          p_err     = 0;
    logic [3:0]  p_sw      = '0;
    logic [31:0] p_wd      = '0;
    int          p_idx     = 0;
    bit          exp_busy  = 0;
    bit          exp_ok    = 0;
    bit          exp_err   = 0;
    logic [31:0] exp_rd    = '0;

    always @(posedge clk) begin
      logic [31:0] w;
      edge_n++;
      if (!rst_s) begin
        pend = 0; free_edge = 0;
        exp_busy = 0; exp_ok = 0; exp_err = 0; exp_rd = '0;
      end else begin
        if (pend && edge_n == resp_edge + 1) begin
          if (p_we && !p_err) begin
            w = mm.exists(p_idx) ? mm[p_idx] : 32'h0;
            for (int b = 0; b < 4; b++)
              if (p_sw[b]) w[8*b +: 8] = p_wd[8*b +: 8];
            mm[p_idx] = w;
          end
          pend = 0;
        end
        if (!pend && edge_n >= free_edge && req_s) begin
          pend      = 1;
          p_we      = we_s;
          p_sw      = sw_s;
          p_wd      = wdata_s;
          p_idx     = int'((addr_s / 4) % (1 << AW));
          p_err     = (addr_s >= 32'(1 << (AW + 2))) || (we_s && sw_s == 4'b0000);
          resp_edge = edge_n + LAT - 1;
          free_edge = edge_n + LAT + 1;
        end
        exp_busy = pend;
        exp_ok   = pend && (edge_n == resp_edge);
        exp_err  = exp_ok && p_err;
        exp_rd   = (exp_ok && !p_we && !p_err && mm.exists(p_idx)) ? mm[p_idx] : 32'h0;
      end
    end

    // ------------------------------------------------ per-cycle compare
    always @(negedge clk) begin
      if (!rst_s) begin
        chk(LAT, "reset busy",    32'(busy_s), 32'h0);
        chk(LAT, "reset data_ok", 32'(ok_s),   32'h0);
        chk(LAT, "reset err",     32'(err_s),  32'h0);
        chk(LAT, "reset rdata",   rdata_s,     32'h0);
      end else begin
        chk(LAT, "busy",    32'(busy_s), 32'(exp_busy));
        chk(LAT, "data_ok", 32'(ok_s),   32'(exp_ok));
        chk(LAT, "err",     32'(err_s),  32'(exp_err));
        chk(LAT, "rdata",   rdata_s,     exp_rd);
      end
    end

    // ------------------------------------------------ one access, start to data_ok
    task automatic txn(input logic we, input logic [3:0] sw, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e,
                       output int lat);
      int  t;
      bit  got;
      rd = '0; e = 1'b0; lat = 0; t = 0; got = 0;
      @(posedge clk); #2;
      req_s = 1'b1; we_s = we; sw_s = sw; addr_s = a; wdata_s = wd;
      do begin
        @(posedge clk); #1; t++;
      end while (!busy_s && t < 20);
      req_s = 1'b0;
      if (!busy_s) begin
        chk(LAT, "accept timeout", 32'(busy_s), 32'h1);
      end else begin
        lat = 1;
        while (!got && lat <= 20) begin
          @(negedge clk);
          if (ok_s) begin
            rd = rdata_s; e = err_s; got = 1;
          end else begin
            lat++;
          end
        end
        if (!got) chk(LAT, "data_ok timeout", 32'(ok_s), 32'h1);
      end
    endtask

    initial begin : stim
      logic [31:0] rd;
      logic        e;
      int          lat;
      int          t;
      int          pulses;
      logic [31:0] a;

      repeat (3) @(posedge clk);
      #1;
      chk(LAT, "por busy",    32'(busy_s), 32'h0);
      chk(LAT, "por data_ok", 32'(ok_s),   32'h0);
      chk(LAT, "por rdata",   rdata_s,     32'h0);
      #1;
      rst_s = 1'b1;

      // Known contents for the 16 words the rest of the run touches.
      for (int i = 0; i < 16; i++) begin
        txn(1'b1, 4'hF, 32'(i * 4), 32'h00C0FFEE + 32'(i) * 32'h01000000, rd, e, lat);
        chk(LAT, "preload err", 32'(e), 32'h0);
      end

      // Full store then load, latency measured from acceptance.
      txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, e, lat);
      chk(LAT, "store latency", 32'(lat), 32'(LAT));
      chk(LAT, "store err", 32'(e), 32'h0);
      chk(LAT, "store rdata", rd, 32'h0);
      txn(1'b0, 4'h0, 32'h10, 32'h0, rd, e, lat);
      chk(LAT, "load latency", 32'(lat), 32'(LAT));
      chk(LAT, "load rdata", rd, 32'hDEADBEEF);
      chk(LAT, "load err", 32'(e), 32'h0);

      // Byte-lane merge.
      txn(1'b1, 4'b0100, 32'h10, 32'h00AA0000, rd, e, lat);
      chk(LAT, "merge store err", 32'(e), 32'h0);
      txn(1'b0, 4'h0, 32'h13, 32'h0, rd, e, lat);
      chk(LAT, "merge rdata", rd, 32'hDEAABEEF);

      // Range error on load and store; word 0 untouched.
      txn(1'b0, 4'h0, 32'h00001000, 32'h0, rd, e, lat);
      chk(LAT, "range load err", 32'(e), 32'h1);
      chk(LAT, "range load rdata", rd, 32'h0);
      txn(1'b1, 4'hF, 32'h00001000, 32'hFFFFFFFF, rd, e, lat);
      chk(LAT, "range store err", 32'(e), 32'h1);
      txn(1'b0, 4'h0, 32'h0, 32'h0, rd, e, lat);
      chk(LAT, "word0 after range", rd, 32'h00C0FFEE);

      // Enable error: store with no lanes.
      txn(1'b1, 4'h0, 32'h20, 32'h12345678, rd, e, lat);
      chk(LAT, "enable err", 32'(e), 32'h1);
      txn(1'b0, 4'h0, 32'h20, 32'h0, rd, e, lat);
      chk(LAT, "word8 after enable err", rd, 32'h08C0FFEE);

      // req held high across three accesses.
      @(posedge clk); #2;
      req_s = 1'b1; we_s = 1'b0; sw_s = 4'h0; addr_s = 32'h10;
      pulses = 0;
      for (int k = 1; k <= 3 * (LAT + 1); k++) begin
        @(posedge clk); #1;
        chk(LAT, "busy pattern", 32'(busy_s), 32'(((k - 1) % (LAT + 1)) < LAT));
        @(negedge clk);
        if (ok_s) pulses++;
      end
      req_s = 1'b0;
      chk(LAT, "held req data_ok pulses", 32'(pulses), 32'h3);

      // Reset while a store to 0x30 is outstanding.
      @(posedge clk); #2;
      req_s = 1'b1; we_s = 1'b1; sw_s = 4'hF; addr_s = 32'h30; wdata_s = 32'h5555AAAA;
      t = 0;
      do begin
        @(posedge clk); #1; t++;
      end while (!busy_s && t < 20);
      req_s = 1'b0;
      chk(LAT, "abort store accepted", 32'(busy_s), 32'h1);
      rst_s = 1'b0;
      #1;
      chk(LAT, "busy on reset", 32'(busy_s), 32'h0);
      repeat (3) begin
        @(negedge clk);
        chk(LAT, "data_ok in reset", 32'(ok_s), 32'h0);
      end
      @(posedge clk); #2;
      rst_s = 1'b1;
      repeat (LAT + 2) begin
        @(negedge clk);
        chk(LAT, "data_ok after abort", 32'(ok_s), 32'h0);
      end
      txn(1'b0, 4'h0, 32'h30, 32'h0, rd, e, lat);
      chk(LAT, "word 0x30 after abort", rd, 32'h0CC0FFEE);

      // Random traffic, checked cycle by cycle against the model.
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 9) == 0)
          a = $urandom | 32'h00001000;
        else
          a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, rd, e, lat);
        chk(LAT, "random latency", 32'(lat), 32'(LAT));
      end

      done[gi] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(done[0] && done[1]) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    chk(0, "completion", 32'({done[0], done[1]}), 32'h3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving log2 of the word count (1024 x 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, giving the number of cycles from request acceptance to the data_ok cycle (legal range 1..8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port req, input, 1, request valid from the datapath's memory stage.
REQ-006 SHALL have port memwrite, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port sig_write, input, 4, byte-lane write enables (bit i = byte lane i), already lane-aligned by the initiator.
REQ-008 SHALL have port addr, input, 32, byte address (the initiator's aluoutM).
REQ-009 SHALL have port wdata, input, 32, lane-aligned store data.
REQ-010 SHALL have port rdata, output, 32, full read word.
REQ-011 SHALL have port data_ok, output, 1, one-cycle response strobe.
REQ-012 SHALL have port busy, output, 1, registered; high while a request is outstanding.
REQ-013 SHALL have port err, output, 1, error flag, valid only when data_ok is high.

Function
REQ-014 SHALL implement a three-state FSM (IDLE, WAIT, RESP), encoded in registers.
REQ-015 SHALL accept a request on any rising edge where state = IDLE and req = 1.
- At acceptance SHALL capture memwrite, sig_write, addr and wdata into holding registers.
- Inputs SHALL be ignored in all other states.
REQ-016 On acceptance SHALL go to RESP if LATENCY = 1; otherwise SHALL go to WAIT and load the wait counter with LATENCY-2.
REQ-017 In WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter is 0.
REQ-018 From RESP SHALL always go to IDLE, so a new request is accepted no earlier than one cycle after data_ok.
- Throughput is one access per LATENCY+1 cycles.
REQ-019 busy SHALL be 1 exactly when state is WAIT or RESP.
REQ-020 data_ok SHALL be 1 only in RESP, for exactly one cycle per accepted request.
- data_ok rises LATENCY cycles after the acceptance edge.
REQ-021 Word index SHALL be held_addr[ADDR_W+1:2]; byte offset held_addr[1:0] SHALL be ignored for indexing.
REQ-022 Range error: held_addr[31:ADDR_W+2] is nonzero.
REQ-023 Enable error: held memwrite = 1 and held sig_write = 4'b0000.
REQ-024 err SHALL equal (range error OR enable error) during RESP, and 0 otherwise.
REQ-025 Load without error: rdata SHALL be the addressed word during RESP; sig_write is ignored on loads.
REQ-026 Store without error: only lanes i with sig_write[i] = 1 SHALL be updated, with wdata[8i+7:8i], at the RESP clock edge.
- Other lanes SHALL be unchanged.
- rdata SHALL be 0 during a store's RESP.
REQ-027 On error SHALL perform no memory write, and rdata SHALL be 0.
REQ-028 Outside RESP, rdata SHALL be 0.
REQ-029 A store followed by a load to the same word SHALL return the merged post-store word.
REQ-030 The storage array SHALL be synchronous single-port; it is written only in RESP and read from the held address.

Reset
REQ-031 While rst = 0, regardless of clk:
- state SHALL be IDLE and the wait counter 0;
- busy, data_ok and err SHALL be 0, and rdata SHALL be 32'h0;
- holding registers SHALL be cleared.
REQ-032 Reset asserted in WAIT or RESP SHALL abort the pending access.
- No memory write occurs on or after the asserting edge.
- No data_ok is produced for the aborted request.
REQ-033 Storage contents are not reset; their power-up value is unspecified.
REQ-034 After rst deasserts, the first request SHALL be accepted on the first rising edge with req = 1.

Verification
REQ-035 LATENCY=2: store addr=0x10, sig_write=1111, wdata=0xDEADBEEF, then load 0x10 -> each data_ok comes 2 cycles after acceptance; load rdata=0xDEADBEEF, err=0.
REQ-036 Byte merge: word 0x10 = 0xDEADBEEF; store sig_write=0100, wdata=0x00AA0000; load 0x13 -> rdata=0xDEAABEEF.
REQ-037 Range error: load addr=0x00001000 with ADDR_W=10 -> data_ok=1, err=1, rdata=0. Store to same address -> err=1; word 0 unchanged on readback.
REQ-038 Enable error: store sig_write=0000 to 0x20 -> err=1; readback of 0x20 unchanged.
REQ-039 Busy rules: hold req=1 continuously for three loads -> accepted on IDLE cycles only, busy pattern 1,1,0 repeating, exactly three data_ok pulses. Also LATENCY=1: data_ok one cycle after acceptance.
REQ-040 Reset mid-operation: assert rst=0 during WAIT of a store to 0x30 -> busy=0 immediately, no data_ok, word 0x30 retains its prior value on a later load.
